temp_state_classifier: RTL and testbench

//   Turns the sampled temperature reading into the 2-bit alarm state used by the buzzer path
//   (0 = frio, 1 = normal, 2 = quente). It sits between the sensor/ADC sampler and the buzzer

---
 rtl/temp_state_classifier.sv | 169 ++++++++++++++++
 tb/tb_temp_state_classifier.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/temp_state_classifier.sv
// Temperature band classifier feeding the buzzer controller: hysteresis on band exits,
// N-sample confirmation before estado moves, and a sensor-silence fault that parks estado at normal.
`timescale 1ns/1ps
module temp_state_classifier #(
    parameter int unsigned TW         = 32'd8,
    parameter int unsigned LIM_FRIO   = 32'd18,
    parameter int unsigned LIM_QUENTE = 32'd30,
    parameter int unsigned HIST       = 32'd2,
    parameter int unsigned CONFIRMA   = 32'd4,
    parameter int unsigned TIMEOUT    = 32'd100_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TW-1:0] temp,
    input  logic          temp_valid,
    output logic [1:0]    estado,
    output logic          mudou,
    output logic          falha
);

    localparam int unsigned CW  = $clog2(CONFIRMA + 32'd1);
    localparam int unsigned TOW = $clog2(TIMEOUT + 32'd1);

    localparam logic [1:0] EST_FRIO   = 2'd0;
    localparam logic [1:0] EST_NORMAL = 2'd1;
    localparam logic [1:0] EST_QUENTE = 2'd2;

    // Thresholds are held one bit wider than the sample so LIM_FRIO+HIST cannot wrap.
    localparam logic [TW:0] TH_FRIO       = (TW+1)'(LIM_FRIO);
    localparam logic [TW:0] TH_FRIO_SAI   = (TW+1)'(LIM_FRIO + HIST);
    localparam logic [TW:0] TH_QUENTE     = (TW+1)'(LIM_QUENTE);
    localparam logic [TW:0] TH_QUENTE_SAI = (TW+1)'(LIM_QUENTE - HIST);

    localparam logic [CW-1:0]  CONF_MAX = CW'(CONFIRMA);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(32'd0);
    localparam logic [TOW-1:0] TO_MAX   = TOW'(TIMEOUT);
    localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT - 32'd1);
    localparam logic [TOW-1:0] TO_ONE   = TOW'(32'd1);
    localparam logic [TOW-1:0] TO_ZERO  = TOW'(32'd0);

    function automatic logic [1:0] classify(input logic [TW:0] t, input logic [1:0] est);
        logic [1:0] c;
        c = EST_NORMAL;
        case (est)
            EST_FRIO: begin
                if (t > TH_QUENTE)         c = EST_QUENTE;
                else if (t >= TH_FRIO_SAI) c = EST_NORMAL;
                else                       c = EST_FRIO;
            end
            EST_QUENTE: begin
                if (t < TH_FRIO)             c = EST_FRIO;
                else if (t <= TH_QUENTE_SAI) c = EST_NORMAL;
                else                         c = EST_QUENTE;
            end
            default: begin
                if (t < TH_FRIO)        c = EST_FRIO;
                else if (t > TH_QUENTE) c = EST_QUENTE;
                else                    c = EST_NORMAL;
            end
        endcase
        return c;
    endfunction

    logic [1:0]     r_estado;
    logic           r_mudou;
    logic           r_falha;
    logic [CW-1:0]  r_cnt;
    logic [1:0]     r_cand;
    logic [TOW-1:0] r_to_cnt;

    logic [TW:0]    w_temp_x;
    logic [1:0]     w_cand;
    logic [CW-1:0]  w_cnt_inc;
    logic [CW-1:0]  w_cnt_upd;
    logic           w_to_fire;
    logic [TOW-1:0] w_to_nx;
    logic [1:0]     w_estado_nx;
    logic [CW-1:0]  w_cnt_nx;
    logic [1:0]     w_cand_nx;
    logic           w_falha_nx;
    logic           w_mudou_nx;

    assign w_temp_x = {1'b0, temp};
    assign w_cand   = classify(w_temp_x, r_estado);

    // Silence counter; a sample on the expiry edge takes priority over the fault.
    always_comb begin
        w_to_nx   = r_to_cnt;
        w_to_fire = 1'b0;
        if (temp_valid) begin
            w_to_nx = TO_ZERO;
        end else if (r_to_cnt != TO_MAX) begin
            w_to_nx   = r_to_cnt + TO_ONE;
            w_to_fire = (r_to_cnt == TO_LAST);
        end else begin
            w_to_nx = r_to_cnt;
        end
    end

    // Run length of the disagreeing candidate, saturating at CONFIRMA.
    always_comb begin
        w_cnt_inc = r_cnt;
        w_cnt_upd = r_cnt;
        if (r_cnt != CONF_MAX) begin
            w_cnt_inc = r_cnt + CNT_ONE;
        end else begin
            w_cnt_inc = r_cnt;
        end
        if (w_cand == r_cand) begin
            w_cnt_upd = w_cnt_inc;
        end else begin
            w_cnt_upd = CNT_ONE;
        end
    end

    // Next estado / confirmation / fault decision for this edge.
    always_comb begin
        w_estado_nx = r_estado;
        w_cnt_nx    = r_cnt;
        w_cand_nx   = r_cand;
        w_falha_nx  = r_falha;
        if (temp_valid) begin
            w_falha_nx = 1'b0;
            if (w_cand == r_estado) begin
                w_cnt_nx = CNT_ZERO;
            end else begin
                w_cand_nx = w_cand;
                if (w_cnt_upd == CONF_MAX) begin
                    w_estado_nx = w_cand;
                    w_cnt_nx    = CNT_ZERO;
                end else begin
                    w_cnt_nx = w_cnt_upd;
                end
            end
        end else if (w_to_fire) begin
            w_falha_nx  = 1'b1;
            w_cnt_nx    = CNT_ZERO;
            w_estado_nx = EST_NORMAL;
        end else begin
            w_estado_nx = r_estado;
        end
        w_mudou_nx = (w_estado_nx != r_estado);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado <= EST_NORMAL;
            r_mudou  <= 1'b0;
            r_falha  <= 1'b0;
            r_cnt    <= CNT_ZERO;
            r_cand   <= EST_NORMAL;
            r_to_cnt <= TO_ZERO;
        end else begin
            r_estado <= w_estado_nx;
            r_mudou  <= w_mudou_nx;
            r_falha  <= w_falha_nx;
            r_cnt    <= w_cnt_nx;
            r_cand   <= w_cand_nx;
            r_to_cnt <= w_to_nx;
        end
    end

    assign estado = r_estado;
    assign mudou  = r_mudou;
    assign falha  = r_falha;

endmodule

// File: tb/tb_temp_state_classifier.sv
// Bench for temp_state_classifier: directed scenarios with literal expectations plus
// randomized runs, all compared every cycle against a band/run-length reference model.
`timescale 1ns/1ps
module tb_temp_state_classifier;

    localparam int LF   = 18;
    localparam int LQ   = 30;
    localparam int H    = 2;
    localparam int CONF = 4;
    localparam int TO   = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] temp = 8'd0;
    logic       temp_valid = 1'b0;
    logic [1:0] estado;
    logic       mudou;
    logic       falha;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int m_est = 1;
    int m_mud = 0;
    int m_fal = 0;
    int m_run_cand = 1;
    int m_run_len = 0;
    int m_silent = 0;

    temp_state_classifier #(
        .TW(8), .LIM_FRIO(LF), .LIM_QUENTE(LQ), .HIST(H), .CONFIRMA(CONF), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .temp(temp), .temp_valid(temp_valid),
        .estado(estado), .mudou(mudou), .falha(falha)
    );

    always #5 clk = ~clk;

    function automatic int band(int t, int est);
        if (est == 0) return (t > LQ) ? 2 : (t >= LF + H) ? 1 : 0;
        if (est == 2) return (t < LF) ? 0 : (t <= LQ - H) ? 1 : 2;
        return (t < LF) ? 0 : (t > LQ) ? 2 : 1;
    endfunction

    task automatic model_step(input int v, input int t, input int rn);
        int prev;
        int c;
        if (rn == 0) begin
            m_est = 1; m_mud = 0; m_fal = 0; m_run_cand = 1; m_run_len = 0; m_silent = 0;
        end else begin
            prev = m_est;
            if (v != 0) begin
                m_silent = 0;
                m_fal = 0;
                c = band(t, m_est);
                if (c == m_est) begin
                    m_run_len = 0;
                end else begin
                    if (c == m_run_cand) m_run_len = (m_run_len < CONF) ? m_run_len + 1 : CONF;
                    else begin m_run_cand = c; m_run_len = 1; end
                    if (m_run_len >= CONF) begin m_est = c; m_run_len = 0; end
                end
            end else if (m_silent < TO) begin
                m_silent++;
                if (m_silent == TO) begin m_fal = 1; m_run_len = 0; m_est = 1; end
            end
            m_mud = (m_est != prev) ? 1 : 0;
        end
    endtask

    task automatic step(input int v, input int t, input int rn);
        @(negedge clk);
        temp_valid = (v != 0);
        temp = 8'(t);
        rst_n = (rn != 0);
        model_step(v, t, rn);
        @(posedge clk);
        #1;
        n_vec++;
        if (estado !== 2'(m_est) || mudou !== (m_mud != 0) || falha !== (m_fal != 0)) begin
            n_err++;
            $display("FAIL model t=%0t: got estado=%0d mudou=%0b falha=%0b, need estado=%0d mudou=%0d falha=%0d",
                     $time, estado, mudou, falha, m_est, m_mud, m_fal);
        end
    endtask

    task automatic check_lit(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, need %0d", name, act, exp);
        end
    endtask

    task automatic samples(input int n, input int t);
        for (int i = 0; i < n; i++) step(1, t, 1);
    endtask

    initial begin
        // 1 reset
        step(0, 0, 0);
        step(0, 0, 0);
        check_lit("reset_estado", int'(estado), 1);
        check_lit("reset_mudou", int'(mudou), 0);
        check_lit("reset_falha", int'(falha), 0);

        // 2 cold entry
        samples(3, 15);
        check_lit("cold_3_estado", int'(estado), 1);
        step(1, 15, 1);
        check_lit("cold_4_estado", int'(estado), 0);
        check_lit("cold_4_mudou", int'(mudou), 1);
        step(0, 0, 1);
        check_lit("cold_pulse_end", int'(mudou), 0);

        // 3 hysteresis on both sides
        samples(4, 19);
        check_lit("hyst_19_stays_frio", int'(estado), 0);
        samples(4, 20);
        check_lit("hyst_20_normal", int'(estado), 1);
        samples(4, 35);
        check_lit("hot_entry", int'(estado), 2);
        samples(4, 29);
        check_lit("hyst_29_stays_quente", int'(estado), 2);
        samples(4, 28);
        check_lit("hyst_28_normal", int'(estado), 1);

        // 4 alternation never confirms
        for (int i = 0; i < 16; i++) begin
            step(1, (i % 2 == 0) ? 15 : 35, 1);
            check_lit("alt_mudou", int'(mudou), 0);
        end
        check_lit("alt_estado", int'(estado), 1);

        // 5 reset discards partial count
        samples(3, 35);
        step(0, 0, 0);
        step(1, 35, 1);
        check_lit("rst_mid_estado", int'(estado), 1);
        samples(3, 35);
        check_lit("rst_mid_after4", int'(estado), 2);

        // 6 timeout from quente
        for (int i = 0; i < TO - 1; i++) step(0, 0, 1);
        check_lit("to_19_falha", int'(falha), 0);
        step(0, 0, 1);
        check_lit("to_falha", int'(falha), 1);
        check_lit("to_estado", int'(estado), 1);
        check_lit("to_mudou", int'(mudou), 1);
        step(1, 25, 1);
        check_lit("to_clear_falha", int'(falha), 0);
        check_lit("to_clear_estado", int'(estado), 1);

        // sample on the expiry edge beats the fault
        for (int i = 0; i < TO - 1; i++) step(0, 0, 1);
        step(1, 25, 1);
        check_lit("to_race_falha", int'(falha), 0);

        // randomized runs around the thresholds
        for (int k = 0; k < 700; k++) begin
            int r;
            int t;
            int len;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                step(0, 0, 0);
            end else if (r < 5) begin
                len = int'($urandom_range(TO - 2, TO + 4));
                for (int i = 0; i < len; i++) step(0, 0, 1);
            end else begin
                if ($urandom_range(0, 3) == 0) t = int'($urandom_range(0, 255));
                else t = int'($urandom_range(LF - 4, LQ + 4));
                len = int'($urandom_range(1, 6));
                for (int i = 0; i < len; i++) step(($urandom_range(0, 3) != 0) ? 1 : 0, t, 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
